// File: rtl/shift_add_mult16.sv
// shift_add_mult16: sequential unsigned shift-and-add multiplier.
// A WIDTH-bit ripple adder is stepped once per clock with the partial-product
// high half (A) and the multiplicand (M), gated by the current multiplier bit.
// The adder carry is folded back into the top of A on the right shift.
// Handshake: start accepted in IDLE; done is a one-cycle pulse when the
// product is valid. busy stays high until done drops.
module shift_add_mult16 #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     m_r;        // multiplicand
  logic [WIDTH-1:0]     a_r;        // partial product, high half
  logic [WIDTH-1:0]     q_r;        // multiplier, shifted out as low half grows
  logic                 c_r;        // carry register, cleared by every shift
  logic [CNT_W-1:0]     cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic [2*WIDTH-1:0]   product_r;

  logic [WIDTH-1:0]     addend_s;
  logic [WIDTH:0]       sum_s;      // {c_out, sum}

  // Bit-level ripple-carry adder; returns {carry_out, sum}.
  function automatic logic [WIDTH:0] ripple_add(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             cin
  );
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s;
    carry    = '0;
    s        = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]       = x[i] ^ y[i] ^ carry[i];
      carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end
    return {carry[WIDTH], s};
  endfunction

  // Adder datapath: add M only when the current multiplier bit is set.
  // c_r is zero whenever it is consumed (the shift always clears it), so the
  // adder carry-in is effectively zero.
  always_comb begin
    addend_s = '0;
    sum_s    = '0;
    if (q_r[0]) begin
      addend_s = m_r;
    end else begin
      addend_s = '0;
    end
    sum_s = ripple_add(a_r, addend_s, c_r);
  end

  // Control FSM plus datapath registers; all outputs come from here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      m_r       <= '0;
      a_r       <= '0;
      q_r       <= '0;
      c_r       <= 1'b0;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            m_r     <= a;
            q_r     <= b;
            a_r     <= '0;
            c_r     <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // {C,A,Q} <= {0, c_out, sum, Q} >> 1
          c_r    <= 1'b0;
          a_r    <= sum_s[WIDTH:1];
          q_r    <= {sum_s[0], q_r[WIDTH-1:1]};
          cnt_r  <= cnt_r + CNT_ONE;
          busy_r <= 1'b1;
          done_r <= 1'b0;
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          // busy stays high through the done cycle so both drop together.
          product_r <= {a_r, q_r};
          done_r    <= 1'b1;
          busy_r    <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_shift_add_mult16.sv
// Self-checking bench for shift_add_mult16: directed scenarios plus a
// randomized back-to-back run compared against a plain-arithmetic model.
module tb_shift_add_mult16;

  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  shift_add_mult16 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Free-running edge counter used to measure done spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain 64-bit unsigned product.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    p = {48'd0, x} * {48'd0, y};
    return p[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen; edges = number of edges taken, -1 on timeout.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222;
    repeat (3) tick();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (product !== 32'h0) $display("FAIL reset_product: got %h want 0", product); else n_pass++;
    rst = 1'b0; start = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int e;
    a = 16'd3; b = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL t1_busy_run: got %b want 1", busy); else n_pass++;
    wait_done(e);
    n_total++; if (e !== 17) $display("FAIL t1_latency: got %0d edges want 17", e); else n_pass++;
    n_total++; if (product !== 32'h0000000F) $display("FAIL t1_product: got %h want 0000000f", product); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL t1_busy_with_done: got %b want 1", busy); else n_pass++;
    tick();
    n_total++; if (done !== 1'b0) $display("FAIL t1_done_pulse: got %b want 0", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL t1_busy_after: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_carry();
    int e;
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(e);
    n_total++; if (e !== 17) $display("FAIL t2_latency: got %0d edges want 17", e); else n_pass++;
    n_total++; if (product !== 32'hFFFE0001) $display("FAIL t2_product: got %h want fffe0001", product); else n_pass++;
    tick();
  endtask

  task automatic test_zero_identity();
    int e;
    a = 16'h1234; b = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_total++; if (product !== 32'hFFFE0001) $display("FAIL t3_hold_in_run: got %h want fffe0001", product); else n_pass++;
    wait_done(e);
    n_total++; if (product !== ref_mul(16'h1234, 16'h0000)) $display("FAIL t3_zero: got %h want 0", product); else n_pass++;
    tick();
    a = 16'h1234; b = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(e);
    n_total++; if (product !== 32'h00001234) $display("FAIL t3_identity: got %h want 00001234", product); else n_pass++;
    tick();
  endtask

  task automatic test_protocol();
    int n_done;
    int e_first;
    n_done  = 0;
    e_first = -1;
    a = 16'd2; b = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    a = 16'd7; b = 16'd9; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL t4_busy_ignored: got %b want 1", busy); else n_pass++;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (done === 1'b1) begin
        n_done++;
        if (e_first < 0) e_first = k;
      end
    end
    n_total++; if (n_done !== 1) $display("FAIL t4_done_count: got %0d want 1", n_done); else n_pass++;
    n_total++; if (e_first !== 11) $display("FAIL t4_latency: got %0d want 11", e_first); else n_pass++;
    n_total++; if (product !== ref_mul(16'd2, 16'd3)) $display("FAIL t4_product: got %h want 6", product); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int n_done;
    int e;
    n_done = 0;
    a = 16'hABCD; b = 16'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL t5_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (product !== 32'h0) $display("FAIL t5_product_cleared: got %h want 0", product); else n_pass++;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    n_total++; if (n_done !== 0) $display("FAIL t5_no_done: got %0d pulses want 0", n_done); else n_pass++;
    n_total++; if (product !== 32'h0) $display("FAIL t5_product_stays: got %h want 0", product); else n_pass++;
    a = 16'd2; b = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(e);
    n_total++; if (product !== 32'd4) $display("FAIL t5_after_reset: got %h want 4", product); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [2*W-1:0] exp_p;
    int last_done;
    int e;
    last_done = -1;
    a = W'($urandom); b = W'($urandom); start = 1'b1;
    qa.push_back(a); qb.push_back(b);
    for (int i = 0; i < 200; i++) begin
      e = -1;
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (done === 1'b1) begin
          e = k;
          break;
        end
        // Operand noise while running must not disturb the captured pair.
        a = W'($urandom); b = W'($urandom);
      end
      if (e < 0) begin
        n_total++;
        $display("FAIL t6_timeout: op %0d got no done within 40 edges", i);
        break;
      end
      exp_p = ref_mul(qa.pop_front(), qb.pop_front());
      n_total++; if (product !== exp_p) $display("FAIL t6_product[%0d]: got %h want %h", i, product, exp_p); else n_pass++;
      if (i > 0) begin
        n_total++; if (cyc - last_done !== 18) $display("FAIL t6_period[%0d]: got %0d want 18", i, cyc - last_done); else n_pass++;
      end
      last_done = cyc;
      if (i < 199) begin
        a = W'($urandom); b = W'($urandom);
        qa.push_back(a); qb.push_back(b);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    tick();
    tick();
    n_total++; if (busy !== 1'b0) $display("FAIL t6_idle_after: got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_carry();
    test_zero_identity();
    test_protocol();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
